gty_reset_sequencer: RTL and testbench
======================================

Name: gty_reset_sequencer

Overview:
Bring-up and recovery sequencer for one GTY quad: QPLL plus up to four lanes sharing one QPLL. It drives the QPLL reset and the per-quad TX/RX datapath resets in the required order, using the QPLL lock and the lane reset-done indications. It sits directly downstream of the quad PLL wrapper, consuming `qpll_lock` and `refclk_lost`, and upstream of the lane wrappers, feeding their `tx_reset`, `rx_reset`, `txuserrdy` and `rxuserrdy`. It replaces the free-running power-on reset counter used today.

Parameters:
- POWERUP_CYCLES, 16384: cycles all resets are held after `rst` deasserts.
- QPLL_RESET_CYCLES, 32: width of the QPLL reset pulse, in cycles.
- LOCK_STABLE_CYCLES, 1024: consecutive cycles of synced lock required before lock is accepted.
- LOCK_TIMEOUT, 262143: maximum cycles in WAIT_LOCK before a fault.
- DONE_TIMEOUT, 65535: maximum cycles in WAIT_TX or WAIT_RX before a fault.
- BACKOFF_CYCLES, 4096: cycles spent in FAULT before a retry.
- NUM_LANES, 4: number of lanes whose reset-done is ANDed; valid range 1..4.

Ports:
- `clk_156m25`  in  1: sequencer clock. Free-running; lock-detect domain.
- `rst`  in  1: asynchronous, active-high reset.
- `restart`  in  1: synchronous single-cycle software restart request.
- `qpll_lock`  in  1: from the QPLL; asynchronous, synchronized internally.
- `refclk_lost`  in  1: from the QPLL; asynchronous, synchronized internally.
- `tx_resetdone`  in  NUM_LANES: per-lane TX reset done; asynchronous.
- `rx_resetdone`  in  NUM_LANES: per-lane RX reset done; asynchronous.
- `qpll_reset`  out  1: QPLL reset.
- `tx_reset`  out  1: TX datapath reset, common to all lanes.
- `rx_reset`  out  1: RX datapath reset, common to all lanes.
- `tx_userrdy`  out  1: TX user clock ready.
- `rx_userrdy`  out  1: RX user clock ready.
- `link_ready`  out  1: sequence complete and healthy.
- `state_out`  out  3: current state encoding, for VIO/debug.
- `fault_code`  out  2: cause of the last fault. 0 = none, 1 = lock timeout, 2 = resetdone timeout, 3 = lock or refclk lost.
- `retry_count`  out  8: number of FAULT entries; saturates at 255.

Behaviour:
- **Clocking and reset.** One clock. Async active-high `rst`; all registers clear asynchronously; `rst` is released synchronously by the integrating logic.
- **Reset values.**
  - `qpll_reset`, `tx_reset`, `rx_reset` = 1.
  - `tx_userrdy`, `rx_userrdy`, `link_ready` = 0.
  - `fault_code` = 0, `retry_count` = 0, state = POWERUP.
  - Internal timer = 0, synchronizers = 0.
- **Input synchronization.**
  - `qpll_lock`, `refclk_lost` and each resetdone bit pass through a 2-flop synchronizer, giving 2 cycles of latency.
  - The lane done condition is the AND of all NUM_LANES synced bits.
- **Timer.** One shared 20-bit timer, cleared on every state transition; all parameters must be < 2^20.
- **State encodings:** POWERUP=0, QPLL_RST=1, WAIT_LOCK=2, WAIT_TX=3, WAIT_RX=4, READY=5, FAULT=6.
- **POWERUP:** all resets asserted. When timer == POWERUP_CYCLES-1, go to QPLL_RST.
- **QPLL_RST:**
  - `qpll_reset`=1, `tx_reset`=1, `rx_reset`=1.
  - When timer == QPLL_RESET_CYCLES-1, go to WAIT_LOCK.
- **WAIT_LOCK:**
  - `qpll_reset`=0.
  - A stable counter increments while synced lock=1 and clears when it is 0.
  - When the stable counter reaches LOCK_STABLE_CYCLES, go to WAIT_TX.
  - Otherwise, when timer == LOCK_TIMEOUT, go to FAULT with code 1.
- **WAIT_TX:**
  - `tx_reset`=0, `tx_userrdy`=1.
  - When all TX done bits are 1, go to WAIT_RX.
  - When timer == DONE_TIMEOUT, go to FAULT with code 2.
- **WAIT_RX:**
  - `rx_reset`=0, `rx_userrdy`=1; TX outputs stay released.
  - When all RX done bits are 1, go to READY.
  - Timeout goes to FAULT with code 2.
- **READY:**
  - `link_ready`=1, registered: high the cycle after entry.
  - All resets are deasserted; both `userrdy` outputs are 1.
- **FAULT:**
  - Outputs are identical to POWERUP.
  - `retry_count` increments once on entry, saturating at 255.
  - When timer == BACKOFF_CYCLES-1, go to QPLL_RST.
- **Lock-loss check.** In WAIT_TX, WAIT_RX and READY, synced lock=0 or synced `refclk_lost`=1 goes to FAULT with code 3 on the next edge. `link_ready` drops in that same transition.
- **Priority**, highest first: `rst` > `restart` > lock-loss > timeout > normal advance.
- **`restart`.** From any state except POWERUP, go to QPLL_RST next cycle. `fault_code` and `retry_count` are unchanged. `restart` is ignored in POWERUP.
- **Simultaneous completion and timeout.** If done/lock completion and timeout occur in the same cycle, completion wins.
- **`fault_code`** holds its value until the next fault overwrites it; it is never cleared except by `rst`.
- **Outputs** are all registered, with no combinational path from inputs to outputs.

Test Plan:
1. **Nominal bring-up.** Override POWERUP=16, QPLL_RESET=4, STABLE=8. Assert lock at cycle 30; assert all resetdone bits 5 cycles after each reset release.
   - Expected: `qpll_reset` falls at cycle 20.
   - Expected: `tx_reset` falls 8+2 cycles after lock rises.
   - Expected: `link_ready`=1; `retry_count`=0; `fault_code`=0.
2. **Lock never asserts.** LOCK_TIMEOUT=100, BACKOFF=10.
   - Expected: FAULT entered with `fault_code`=1 and `retry_count`=1.
   - Expected: a new `qpll_reset` pulse 10 cycles later.
   - Expected: `retry_count`=3 after three loops.
3. **Lock glitch in WAIT_LOCK.** Drop lock for 1 cycle at stable count 6 of 8.
   - Expected: the stable counter restarts.
   - Expected: WAIT_TX is entered only after 8 further clean cycles.
4. **Lock loss in READY.** Deassert lock.
   - Expected: `link_ready`=0 within 3 cycles; `fault_code`=3; all resets re-asserted.
   - Expected: `link_ready` returns after recovery.
5. **Partial resetdone.** NUM_LANES=3; only bits 0 and 1 of `rx_resetdone` are set.
   - Expected: WAIT_RX times out at DONE_TIMEOUT with `fault_code`=2.
6. **`restart` and async `rst`.**
   - `restart` pulse in READY → QPLL_RST on the next edge, `retry_count` unchanged.
   - `rst` asserted mid-WAIT_TX → all outputs at their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/gty_reset_sequencer.sv
// Reset sequencer for one GTY quad: orders the QPLL reset and the shared TX/RX
// datapath resets, waits on lock and lane reset-done, and retries after faults.
module gty_reset_sequencer #(
  parameter int unsigned POWERUP_CYCLES     = 16384,
  parameter int unsigned QPLL_RESET_CYCLES  = 32,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT       = 262143,
  parameter int unsigned DONE_TIMEOUT       = 65535,
  parameter int unsigned BACKOFF_CYCLES     = 4096,
  parameter int unsigned NUM_LANES          = 4
) (
  input  logic                 clk_156m25,
  input  logic                 rst,
  input  logic                 restart,
  input  logic                 qpll_lock,
  input  logic                 refclk_lost,
  input  logic [NUM_LANES-1:0] tx_resetdone,
  input  logic [NUM_LANES-1:0] rx_resetdone,
  output logic                 qpll_reset,
  output logic                 tx_reset,
  output logic                 rx_reset,
  output logic                 tx_userrdy,
  output logic                 rx_userrdy,
  output logic                 link_ready,
  output logic [2:0]           state_out,
  output logic [1:0]           fault_code,
  output logic [7:0]           retry_count
);

  localparam int unsigned TW = 20;
  localparam int unsigned SW = 2 + 2 * NUM_LANES;

  localparam logic [TW-1:0] POWERUP_LAST = TW'(POWERUP_CYCLES - 1);
  localparam logic [TW-1:0] QRST_LAST    = TW'(QPLL_RESET_CYCLES - 1);
  localparam logic [TW-1:0] STABLE_N     = TW'(LOCK_STABLE_CYCLES);
  localparam logic [TW-1:0] LOCK_TO      = TW'(LOCK_TIMEOUT);
  localparam logic [TW-1:0] DONE_TO      = TW'(DONE_TIMEOUT);
  localparam logic [TW-1:0] BACKOFF_LAST = TW'(BACKOFF_CYCLES - 1);

  localparam logic [1:0] FC_LOCK_TO = 2'd1;
  localparam logic [1:0] FC_DONE_TO = 2'd2;
  localparam logic [1:0] FC_LOST    = 2'd3;

  typedef enum logic [2:0] {
    ST_POWERUP   = 3'd0,
    ST_QPLL_RST  = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_WAIT_TX   = 3'd3,
    ST_WAIT_RX   = 3'd4,
    ST_READY     = 3'd5,
    ST_FAULT     = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] stable_q, stable_d;
  logic [1:0]    fault_code_q, fault_code_d;
  logic [7:0]    retry_q, retry_d;
  logic [SW-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

  logic qpll_reset_q, qpll_reset_d;
  logic tx_reset_q, tx_reset_d;
  logic rx_reset_q, rx_reset_d;
  logic tx_userrdy_q, tx_userrdy_d;
  logic rx_userrdy_q, rx_userrdy_d;
  logic link_ready_q, link_ready_d;

  logic tx_done_s, rx_done_s, lock_s, refclk_lost_s, lock_lost, restart_go;

  // Two-flop synchronizers for every asynchronous status input
  always_comb begin
    sync1_d = {refclk_lost, qpll_lock, rx_resetdone, tx_resetdone};
    sync2_d = sync1_q;
  end

  assign tx_done_s     = &sync2_q[NUM_LANES-1:0];
  assign rx_done_s     = &sync2_q[2*NUM_LANES-1:NUM_LANES];
  assign lock_s        = sync2_q[SW-2];
  assign refclk_lost_s = sync2_q[SW-1];
  assign lock_lost     = !lock_s || refclk_lost_s;
  assign restart_go    = restart && (state_q != ST_POWERUP);

  // Next-state, timer, lock-stability and fault bookkeeping
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + TW'(1);
    stable_d     = '0;
    fault_code_d = fault_code_q;
    retry_d      = retry_q;
    unique case (state_q)
      ST_POWERUP: begin
        if (timer_q == POWERUP_LAST) state_d = ST_QPLL_RST;
      end
      ST_QPLL_RST: begin
        if (timer_q == QRST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        stable_d = lock_s ? stable_q + TW'(1) : '0;
        if (stable_d == STABLE_N) begin
          state_d = ST_WAIT_TX;
        end else if (timer_q == LOCK_TO) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_LOCK_TO;
        end
      end
      ST_WAIT_TX: begin
        if (lock_lost) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_LOST;
        end else if (tx_done_s) begin
          state_d = ST_WAIT_RX;
        end else if (timer_q == DONE_TO) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_DONE_TO;
        end
      end
      ST_WAIT_RX: begin
        if (lock_lost) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_LOST;
        end else if (rx_done_s) begin
          state_d = ST_READY;
        end else if (timer_q == DONE_TO) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_DONE_TO;
        end
      end
      ST_READY: begin
        if (lock_lost) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_LOST;
        end
      end
      ST_FAULT: begin
        if (timer_q == BACKOFF_LAST) state_d = ST_QPLL_RST;
      end
      default: state_d = ST_POWERUP;
    endcase

    // Software restart outranks every fault and advance; it leaves fault history alone
    if (restart_go) begin
      state_d      = ST_QPLL_RST;
      fault_code_d = fault_code_q;
    end

    if (state_d == ST_FAULT && state_q != ST_FAULT && retry_q != 8'hFF) begin
      retry_d = retry_q + 8'd1;
    end

    if (state_d != state_q || restart_go) timer_d = '0;
  end

  // Outputs decoded from the next state so they register together with it
  always_comb begin
    qpll_reset_d = 1'b1;
    tx_reset_d   = 1'b1;
    rx_reset_d   = 1'b1;
    tx_userrdy_d = 1'b0;
    rx_userrdy_d = 1'b0;
    link_ready_d = 1'b0;
    unique case (state_d)
      ST_WAIT_LOCK: begin
        qpll_reset_d = 1'b0;
      end
      ST_WAIT_TX: begin
        qpll_reset_d = 1'b0;
        tx_reset_d   = 1'b0;
        tx_userrdy_d = 1'b1;
      end
      ST_WAIT_RX: begin
        qpll_reset_d = 1'b0;
        tx_reset_d   = 1'b0;
        tx_userrdy_d = 1'b1;
        rx_reset_d   = 1'b0;
        rx_userrdy_d = 1'b1;
      end
      ST_READY: begin
        qpll_reset_d = 1'b0;
        tx_reset_d   = 1'b0;
        tx_userrdy_d = 1'b1;
        rx_reset_d   = 1'b0;
        rx_userrdy_d = 1'b1;
        link_ready_d = 1'b1;
      end
      default: begin
        qpll_reset_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_156m25 or posedge rst) begin
    if (rst) begin
      state_q      <= ST_POWERUP;
      timer_q      <= '0;
      stable_q     <= '0;
      fault_code_q <= '0;
      retry_q      <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      qpll_reset_q <= 1'b1;
      tx_reset_q   <= 1'b1;
      rx_reset_q   <= 1'b1;
      tx_userrdy_q <= 1'b0;
      rx_userrdy_q <= 1'b0;
      link_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      stable_q     <= stable_d;
      fault_code_q <= fault_code_d;
      retry_q      <= retry_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      qpll_reset_q <= qpll_reset_d;
      tx_reset_q   <= tx_reset_d;
      rx_reset_q   <= rx_reset_d;
      tx_userrdy_q <= tx_userrdy_d;
      rx_userrdy_q <= rx_userrdy_d;
      link_ready_q <= link_ready_d;
    end
  end

  assign qpll_reset  = qpll_reset_q;
  assign tx_reset    = tx_reset_q;
  assign rx_reset    = rx_reset_q;
  assign tx_userrdy  = tx_userrdy_q;
  assign rx_userrdy  = rx_userrdy_q;
  assign link_ready  = link_ready_q;
  assign state_out   = state_q;
  assign fault_code  = fault_code_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_gty_reset_sequencer.sv
// Self-checking bench for gty_reset_sequencer with shortened timing parameters;
// expected event times come from cycle arithmetic on the sequencing rules.
`timescale 1ns/1ps
module tb_gty_reset_sequencer;

  localparam int unsigned P  = 16;
  localparam int unsigned Q  = 4;
  localparam int unsigned S  = 8;
  localparam int unsigned LT = 100;
  localparam int unsigned DT = 60;
  localparam int unsigned B  = 10;
  localparam int unsigned N  = 3;

  logic         clk = 1'b0;
  logic         rst, restart, qpll_lock, refclk_lost;
  logic [N-1:0] tx_resetdone, rx_resetdone;
  logic         qpll_reset, tx_reset, rx_reset, tx_userrdy, rx_userrdy, link_ready;
  logic [2:0]   state_out;
  logic [1:0]   fault_code;
  logic [7:0]   retry_count;

  int cyc = 0;
  int t0  = 0;
  int n_cmp = 0;
  int n_err = 0;

  gty_reset_sequencer #(
    .POWERUP_CYCLES(P), .QPLL_RESET_CYCLES(Q), .LOCK_STABLE_CYCLES(S),
    .LOCK_TIMEOUT(LT), .DONE_TIMEOUT(DT), .BACKOFF_CYCLES(B), .NUM_LANES(N)
  ) dut (
    .clk_156m25(clk), .rst(rst), .restart(restart), .qpll_lock(qpll_lock),
    .refclk_lost(refclk_lost), .tx_resetdone(tx_resetdone), .rx_resetdone(rx_resetdone),
    .qpll_reset(qpll_reset), .tx_reset(tx_reset), .rx_reset(rx_reset),
    .tx_userrdy(tx_userrdy), .rx_userrdy(rx_userrdy), .link_ready(link_ready),
    .state_out(state_out), .fault_code(fault_code), .retry_count(retry_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; restart = 1'b0; qpll_lock = 1'b0; refclk_lost = 1'b0;
    tx_resetdone = '0; rx_resetdone = '0;
    repeat (3) tick();
    rst = 1'b0;
    t0 = cyc;
  endtask

  // Lane/PLL stand-in: raises lock at lock_at, raises each done dtx/drx cycles after the
  // matching reset release, and reports the cycles at which the DUT outputs moved.
  task automatic drive_bringup(input int lock_at, input int dtx, input int drx,
                               input logic [N-1:0] rx_mask, input int budget,
                               output int t_qf, output int t_txf, output int t_rxf,
                               output int t_rdy, output int t_flt);
    t_qf = -1; t_txf = -1; t_rxf = -1; t_rdy = -1; t_flt = -1;
    tx_resetdone = '0; rx_resetdone = '0;
    if (cyc >= lock_at) qpll_lock = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (t_qf < 0 && qpll_reset === 1'b0) t_qf = cyc;
      if (t_txf < 0 && tx_reset === 1'b0) t_txf = cyc;
      if (t_rxf < 0 && rx_reset === 1'b0) t_rxf = cyc;
      if (link_ready === 1'b1) begin t_rdy = cyc; break; end
      if (t_qf >= 0 && state_out === 3'd6) begin t_flt = cyc; break; end
      if (cyc >= lock_at) qpll_lock = 1'b1;
      if (t_txf >= 0 && cyc == t_txf + dtx) tx_resetdone = '1;
      if (t_rxf >= 0 && cyc == t_rxf + drx) rx_resetdone = rx_mask;
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic test_reset();
    logic [18:0] obs, exp_v;
    rst = 1'b1; restart = 1'b0; qpll_lock = 1'b1; refclk_lost = 1'b0;
    tx_resetdone = '1; rx_resetdone = '1;
    #2;
    exp_v = {6'b111000, 3'd0, 2'd0, 8'd0};
    obs = {qpll_reset, tx_reset, rx_reset, tx_userrdy, rx_userrdy, link_ready,
           state_out, fault_code, retry_count};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL reset_values: got %h expected %h", obs, exp_v);
    end
    apply_reset();
    tick();
    obs = {qpll_reset, tx_reset, rx_reset, tx_userrdy, rx_userrdy, link_ready,
           state_out, fault_code, retry_count};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL powerup_hold: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_nominal();
    int l, dtx, drx, qf, txf, rxf, rdy, flt, e_tx, e_rx, e_rdy;
    for (int it = 0; it < 3; it++) begin
      if (it == 0) begin l = 30; dtx = 5; drx = 5; end
      else begin
        l = $urandom_range(0, 40); dtx = $urandom_range(1, 20); drx = $urandom_range(1, 20);
      end
      apply_reset();
      drive_bringup(t0 + l, dtx, drx, '1, 400, qf, txf, rxf, rdy, flt);
      e_tx  = imax(P + Q + 1, l + 3) + S - 1;
      e_rx  = e_tx + dtx + 3;
      e_rdy = e_rx + drx + 3;
      n_cmp++;
      if (qf - t0 != P + Q) begin
        n_err++; $display("FAIL nominal_qpll_fall: got %0d expected %0d", qf - t0, P + Q);
      end
      n_cmp++;
      if (txf - t0 != e_tx) begin
        n_err++; $display("FAIL nominal_tx_fall: got %0d expected %0d (lock %0d)", txf - t0, e_tx, l);
      end
      n_cmp++;
      if (rxf - t0 != e_rx) begin
        n_err++; $display("FAIL nominal_rx_fall: got %0d expected %0d", rxf - t0, e_rx);
      end
      n_cmp++;
      if (rdy - t0 != e_rdy) begin
        n_err++; $display("FAIL nominal_ready: got %0d expected %0d", rdy - t0, e_rdy);
      end
      n_cmp++;
      if ({qpll_reset, tx_reset, rx_reset, tx_userrdy, rx_userrdy, state_out, fault_code, retry_count}
          !== {5'b00011, 3'd5, 2'd0, 8'd0}) begin
        n_err++;
        $display("FAIL nominal_ready_outputs: got %b%b%b%b%b st=%0d fc=%0d rc=%0d expected 00011 st=5 fc=0 rc=0",
                 qpll_reset, tx_reset, rx_reset, tx_userrdy, rx_userrdy, state_out, fault_code, retry_count);
      end
    end
  endtask

  task automatic test_lock_timeout();
    int t_f, t_prev;
    apply_reset();
    t_prev = t0 + P + Q + LT + 1 - (B + Q + LT + 1);
    for (int k = 1; k <= 3; k++) begin
      for (int i = 0; i < 400 && state_out !== 3'd6; i++) tick();
      t_f = cyc;
      n_cmp++;
      if (t_f - t_prev != B + Q + LT + 1) begin
        n_err++; $display("FAIL lock_to_entry%0d: got %0d expected %0d", k, t_f - t_prev, B + Q + LT + 1);
      end
      n_cmp++;
      if (fault_code !== 2'd1 || retry_count !== 8'(k)) begin
        n_err++; $display("FAIL lock_to_code%0d: got fc=%0d rc=%0d expected fc=1 rc=%0d", k, fault_code, retry_count, k);
      end
      for (int i = 0; i < 100 && state_out === 3'd6; i++) tick();
      n_cmp++;
      if (cyc - t_f != B || state_out !== 3'd1 || qpll_reset !== 1'b1) begin
        n_err++; $display("FAIL lock_to_backoff%0d: got %0d st=%0d qr=%b expected %0d st=1 qr=1",
                          k, cyc - t_f, state_out, qpll_reset, B);
      end
      for (int i = 0; i < 100 && qpll_reset !== 1'b0; i++) tick();
      n_cmp++;
      if (cyc - t_f != B + Q) begin
        n_err++; $display("FAIL lock_to_qpll_pulse%0d: got %0d expected %0d", k, cyc - t_f, B + Q);
      end
      t_prev = t_f;
    end
  endtask

  task automatic test_lock_glitch();
    int g, t_tx, rel;
    logic at28;
    g = $urandom_range(1, 7);
    apply_reset();
    t_tx = -1; at28 = 1'bx;
    for (int i = 0; i < 200; i++) begin
      tick();
      rel = cyc - t0;
      if (rel == 28) at28 = tx_reset;
      if (tx_reset === 1'b0) begin t_tx = rel; break; end
      if (rel == 10) qpll_lock = 1'b1;
      if (rel == 18 + g) qpll_lock = 1'b0;
      if (rel == 19 + g) qpll_lock = 1'b1;
    end
    n_cmp++;
    if (at28 !== 1'b1) begin
      n_err++; $display("FAIL glitch_no_early_tx: got %b expected 1 (glitch at count %0d)", at28, g);
    end
    n_cmp++;
    if (t_tx != 29 + g) begin
      n_err++; $display("FAIL glitch_tx_fall: got %0d expected %0d", t_tx, 29 + g);
    end
  endtask

  task automatic test_lock_loss_ready();
    int l, dtx, drx, qf, txf, rxf, rdy, flt, x, r, e_tx, e_rdy;
    logic l2, l3;
    l = $urandom_range(0, 30); dtx = $urandom_range(1, 15); drx = $urandom_range(1, 15);
    apply_reset();
    drive_bringup(t0 + l, dtx, drx, '1, 400, qf, txf, rxf, rdy, flt);
    repeat ($urandom_range(1, 10)) tick();
    x = cyc;
    qpll_lock = 1'b0;
    tick(); tick(); l2 = link_ready;
    tick(); l3 = link_ready;
    n_cmp++;
    if (l2 !== 1'b1 || l3 !== 1'b0) begin
      n_err++; $display("FAIL loss_link_drop: got %b%b expected 10", l2, l3);
    end
    n_cmp++;
    if ({state_out, fault_code, retry_count, qpll_reset, tx_reset, rx_reset, tx_userrdy, rx_userrdy}
        !== {3'd6, 2'd3, 8'd1, 5'b11100}) begin
      n_err++;
      $display("FAIL loss_fault_state: got st=%0d fc=%0d rc=%0d res=%b%b%b%b%b expected st=6 fc=3 rc=1 res=11100",
               state_out, fault_code, retry_count, qpll_reset, tx_reset, rx_reset, tx_userrdy, rx_userrdy);
    end
    r = $urandom_range(0, 20);
    drive_bringup(x + 3 + r, dtx, drx, '1, 400, qf, txf, rxf, rdy, flt);
    e_tx  = imax(x + 3 + B + Q + 1, x + 3 + r + 3) + S - 1;
    e_rdy = e_tx + dtx + 3 + drx + 3;
    n_cmp++;
    if (rdy != e_rdy) begin
      n_err++; $display("FAIL loss_recovery_ready: got %0d expected %0d", rdy - x, e_rdy - x);
    end
    n_cmp++;
    if (fault_code !== 2'd3 || retry_count !== 8'd1) begin
      n_err++; $display("FAIL loss_history_held: got fc=%0d rc=%0d expected fc=3 rc=1", fault_code, retry_count);
    end
  endtask

  task automatic test_partial_rx();
    int l, dtx, drx, qf, txf, rxf, rdy, flt, miss, e_rx;
    logic [N-1:0] mask;
    miss = $urandom_range(0, N - 1);
    mask = '1;
    mask[miss] = 1'b0;
    l = $urandom_range(0, 30); dtx = $urandom_range(1, 15); drx = $urandom_range(1, 15);
    apply_reset();
    drive_bringup(t0 + l, dtx, drx, mask, 400, qf, txf, rxf, rdy, flt);
    e_rx = imax(P + Q + 1, l + 3) + S - 1 + dtx + 3;
    n_cmp++;
    if (rxf - t0 != e_rx) begin
      n_err++; $display("FAIL partial_rx_fall: got %0d expected %0d", rxf - t0, e_rx);
    end
    n_cmp++;
    if (flt - t0 != e_rx + DT + 1) begin
      n_err++; $display("FAIL partial_timeout: got %0d expected %0d (missing lane %0d)", flt - t0, e_rx + DT + 1, miss);
    end
    n_cmp++;
    if (fault_code !== 2'd2 || retry_count !== 8'd1 || link_ready !== 1'b0 || rx_reset !== 1'b1) begin
      n_err++; $display("FAIL partial_fault_code: got fc=%0d rc=%0d lr=%b rr=%b expected fc=2 rc=1 lr=0 rr=1",
                        fault_code, retry_count, link_ready, rx_reset);
    end
  endtask

  task automatic test_restart_rst();
    int qf, txf, rxf, rdy, flt, x;
    apply_reset();
    repeat (5) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    drive_bringup(t0 + 12, 3, 3, '1, 400, qf, txf, rxf, rdy, flt);
    n_cmp++;
    if (qf - t0 != P + Q || rdy < 0) begin
      n_err++; $display("FAIL restart_ignored_powerup: got qf=%0d rdy=%0d expected qf=%0d and ready", qf - t0, rdy, P + Q);
    end
    tick();
    x = cyc;
    restart = 1'b1;
    tx_resetdone = '0; rx_resetdone = '0;
    tick();
    restart = 1'b0;
    n_cmp++;
    if ({state_out, qpll_reset, tx_reset, link_ready, fault_code, retry_count} !== {3'd1, 3'b110, 2'd0, 8'd0}) begin
      n_err++; $display("FAIL restart_in_ready: got st=%0d qr=%b tr=%b lr=%b fc=%0d rc=%0d expected st=1 qr=1 tr=1 lr=0 fc=0 rc=0",
                        state_out, qpll_reset, tx_reset, link_ready, fault_code, retry_count);
    end
    for (int i = 0; i < 60 && state_out !== 3'd3; i++) tick();
    n_cmp++;
    if (cyc - x != 1 + Q + S || tx_userrdy !== 1'b1) begin
      n_err++; $display("FAIL restart_to_wait_tx: got %0d txu=%b expected %0d txu=1", cyc - x, tx_userrdy, 1 + Q + S);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({qpll_reset, tx_reset, rx_reset, tx_userrdy, rx_userrdy, link_ready, state_out, fault_code, retry_count}
        !== {6'b111000, 3'd0, 2'd0, 8'd0}) begin
      n_err++; $display("FAIL async_rst_wait_tx: got %b%b%b%b%b%b st=%0d fc=%0d rc=%0d expected 111000 st=0 fc=0 rc=0",
                        qpll_reset, tx_reset, rx_reset, tx_userrdy, rx_userrdy, link_ready,
                        state_out, fault_code, retry_count);
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; restart = 1'b0; qpll_lock = 1'b0; refclk_lost = 1'b0;
    tx_resetdone = '0; rx_resetdone = '0;
    test_reset();
    test_nominal();
    test_lock_timeout();
    test_lock_glitch();
    test_lock_loss_ready();
    test_partial_rx();
    test_restart_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
